fft_stage_sequencer: RTL and testbench

- Controller that drives the twiddle-index counter interface: stage_count_out, k_enable, k_clear.
- Sequences a radix-2 DIT FFT of N = 2^LOG2N points over LOG2N stages and N/2 butterflies per stage.
- For every butterfly it issues the pair of data addresses to the butterfly datapath under a valid/ready handshake.
- Sits between the FFT top-level control (start/abort/done) and the butterfly datapath plus the twiddle-index counter.

---
 rtl/fft_pkg.sv | 14 +
 rtl/fft_stage_sequencer_if.sv | 22 ++
 rtl/bfly_addr_gen.sv | 25 ++
 rtl/fft_stage_sequencer.sv | 104 ++++++++++
 tb/tb_fft_stage_sequencer.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fft_pkg.sv
// Shared constants and types for the radix-2 DIT FFT stage sequencer.
package fft_pkg;
  localparam int LOG2N = 8;
  localparam int N     = 1 << LOG2N;

  typedef logic [3:0] stage_t;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    RUN,
    DONE
  } seq_state_t;
endpackage

// File: rtl/fft_stage_sequencer_if.sv
// Butterfly issue channel: address pair plus stage under a valid/ready handshake.
interface fft_stage_sequencer_if
  import fft_pkg::*;
#(
  parameter int LOG2N = fft_pkg::LOG2N
);
  logic             bfly_valid;
  logic             bfly_ready;
  logic [LOG2N-1:0] addr_a;
  logic [LOG2N-1:0] addr_b;
  stage_t           stage_count_out;

  modport master (
    output bfly_valid, addr_a, addr_b, stage_count_out,
    input  bfly_ready
  );

  modport slave (
    input  bfly_valid, addr_a, addr_b, stage_count_out,
    output bfly_ready
  );
endinterface

// File: rtl/bfly_addr_gen.sv
// Butterfly address pair: insert a zero at bit <stage> of bfly_cnt for the top
// address, set that bit for the bottom address.
module bfly_addr_gen
  import fft_pkg::*;
#(
  parameter int LOG2N = fft_pkg::LOG2N
) (
  input  logic [LOG2N-2:0] bfly_cnt,
  input  stage_t           stage,
  output logic [LOG2N-1:0] addr_a,
  output logic [LOG2N-1:0] addr_b
);
  logic [LOG2N-1:0] cnt_ext;
  logic [LOG2N-1:0] bit_s;
  logic [LOG2N-1:0] low_mask;

  // Bits below the stage stay put; bits at or above move up by one.
  always_comb begin
    cnt_ext  = {1'b0, bfly_cnt};
    bit_s    = LOG2N'(1) << stage;
    low_mask = bit_s - LOG2N'(1);
    addr_a   = ((cnt_ext & ~low_mask) << 1) | (cnt_ext & low_mask);
    addr_b   = addr_a | bit_s;
  end
endmodule

// File: rtl/fft_stage_sequencer.sv
// Stage/butterfly sequencer for an N-point radix-2 DIT FFT; also drives the
// twiddle-index counter clear/advance strobes.
module fft_stage_sequencer
  import fft_pkg::*;
#(
  parameter int LOG2N = fft_pkg::LOG2N
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  start,
  input  logic                  abort,
  fft_stage_sequencer_if.master bfly,
  output logic                  k_enable,
  output logic                  k_clear,
  output logic                  busy,
  output logic                  done
);
  localparam int             CW         = LOG2N - 1;
  localparam logic [CW-1:0]  CNT_LAST   = '1;
  localparam stage_t         STAGE_LAST = stage_t'(LOG2N - 1);

  seq_state_t       state_q, state_d;
  stage_t           stage_q, stage_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             valid;
  logic             accept;
  logic [LOG2N-1:0] gen_a, gen_b;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      stage_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      cnt_q   <= cnt_d;
    end
  end

  assign valid  = (state_q == RUN);
  assign accept = valid & bfly.bfly_ready;

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CLEAR;
          stage_d = '0;
          cnt_d   = '0;
        end
      end
      CLEAR: state_d = RUN;
      RUN: begin
        if (accept) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (stage_q == STAGE_LAST) begin
              state_d = DONE;
            end else begin
              stage_d = stage_q + stage_t'(1);
              state_d = CLEAR;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        stage_d = '0;
        cnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase
    // DONE is left alone so the completion pulse is never swallowed.
    if (abort && (state_q == CLEAR || state_q == RUN)) begin
      state_d = IDLE;
      stage_d = '0;
      cnt_d   = '0;
    end
  end

  bfly_addr_gen #(.LOG2N(LOG2N)) u_addr_gen (
    .bfly_cnt (cnt_q),
    .stage    (stage_q),
    .addr_a   (gen_a),
    .addr_b   (gen_b)
  );

  assign bfly.bfly_valid      = valid;
  assign bfly.addr_a          = valid ? gen_a : '0;
  assign bfly.addr_b          = valid ? gen_b : '0;
  assign bfly.stage_count_out = stage_q;

  // Abort also clears the twiddle counter in the same cycle it is presented.
  assign k_enable = accept;
  assign k_clear  = (state_q == CLEAR) | (abort & (state_q != IDLE));
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Directed bench for fft_stage_sequencer (N=256) and its address generator.
module tb_fft_stage_sequencer;
  logic clk = 1'b0;
  logic nrst, start, abort;
  logic k_enable, k_clear, busy, done;
  logic [6:0] ag_cnt;
  logic [3:0] ag_stage;
  logic [7:0] ag_a, ag_b;

  int n_tests = 0;
  int n_fail  = 0;
  int kc_tot  = 0;
  int ke_tot  = 0;
  int dn_tot  = 0;
  logic [7:0] tw_idx;

  fft_stage_sequencer_if #(.LOG2N(8)) bif ();

  fft_stage_sequencer #(.LOG2N(8)) dut (
    .clk      (clk),
    .nrst     (nrst),
    .start    (start),
    .abort    (abort),
    .bfly     (bif),
    .k_enable (k_enable),
    .k_clear  (k_clear),
    .busy     (busy),
    .done     (done)
  );

  bfly_addr_gen #(.LOG2N(8)) u_ag (
    .bfly_cnt (ag_cnt),
    .stage    (ag_stage),
    .addr_a   (ag_a),
    .addr_b   (ag_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (nrst) begin
      if (k_clear)  kc_tot <= kc_tot + 1;
      if (k_enable) ke_tot <= ke_tot + 1;
      if (done)     dn_tot <= dn_tot + 1;
    end
  end

  // Reference twiddle-index counter: clear wins, wraps at 2^stage.
  always @(posedge clk or negedge nrst) begin
    if (!nrst)         tw_idx <= 8'd0;
    else if (k_clear)  tw_idx <= 8'd0;
    else if (k_enable) tw_idx <= (tw_idx + 8'd1) & ((8'd1 << bif.stage_count_out) - 8'd1);
  end

  typedef struct {
    logic [6:0] cnt;
    logic [3:0] stg;
    logic [7:0] ea;
    logic [7:0] eb;
  } ag_vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [24:0] cur_vec();
    return {busy, done, bif.bfly_valid, k_clear, k_enable, bif.stage_count_out,
            bif.addr_a, bif.addr_b};
  endfunction

  function automatic logic [15:0] ref_ab(input int s, input int cnt);
    int a;
    a = ((cnt >> s) << (s + 1)) | (cnt & ((1 << s) - 1));
    return {a[7:0], 8'(a | (1 << s))};
  endfunction

  // Expected {busy,done,valid,k_clear,k_enable,stage,a,b} in cycle c after start, ready=1.
  function automatic logic [24:0] exp_vec(input int c);
    int s, r;
    if (c == 1033) return {1'b1, 1'b1, 3'b000, 4'd7, 16'd0};
    if (c > 1033 || c < 1) return 25'd0;
    s = (c - 1) / 129;
    r = (c - 1) % 129;
    if (r == 0) return {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'(s), 16'd0};
    return {1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'(s), ref_ab(s, r - 1)};
  endfunction

  // Caller is at a negedge in IDLE. Start pulse sampled on the next edge (edge 0).
  task automatic launch();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic full_run_checked(input string tag);
    int kc0, ke0, dn0;
    bif.bfly_ready = 1'b1;
    kc0 = kc_tot; ke0 = ke_tot; dn0 = dn_tot;
    launch();
    for (int c = 1; c <= 1035; c++) begin
      #1;
      chk($sformatf("%s_cyc%0d", tag, c), 32'(cur_vec()), 32'(exp_vec(c)));
      @(negedge clk);
    end
    chk({tag, "_kclear_cnt"}, kc_tot - kc0, 8);
    chk({tag, "_kenable_cnt"}, ke_tot - ke0, 1024);
    chk({tag, "_done_cnt"}, dn_tot - dn0, 1);
  endtask

  ag_vec_t tbl[10];

  initial begin
    int ke0, kc0, dn0, m_stage, m_cnt;
    bit found, done_seen;
    logic [15:0] ab;

    tbl[0] = '{7'd0,   4'd0, 8'd0,   8'd1};
    tbl[1] = '{7'd127, 4'd0, 8'd254, 8'd255};
    tbl[2] = '{7'd5,   4'd2, 8'd9,   8'd13};
    tbl[3] = '{7'd127, 4'd7, 8'd127, 8'd255};
    tbl[4] = '{7'd0,   4'd7, 8'd0,   8'd128};
    tbl[5] = '{7'd40,  4'd3, 8'd80,  8'd88};
    tbl[6] = '{7'd3,   4'd1, 8'd5,   8'd7};
    tbl[7] = '{7'd100, 4'd4, 8'd196, 8'd212};
    tbl[8] = '{7'd64,  4'd6, 8'd128, 8'd192};
    tbl[9] = '{7'd31,  4'd5, 8'd31,  8'd63};

    nrst = 1'b0; start = 1'b0; abort = 1'b0; bif.bfly_ready = 1'b0;
    ag_cnt = '0; ag_stage = '0;
    #1;
    chk("reset_async", 32'(cur_vec()), 32'd0);
    repeat (2) @(negedge clk);
    chk("reset_held", 32'(cur_vec()), 32'd0);

    for (int i = 0; i < 10; i++) begin
      ag_cnt = tbl[i].cnt; ag_stage = tbl[i].stg;
      #1;
      chk($sformatf("agen_a_s%0d_c%0d", tbl[i].stg, tbl[i].cnt), 32'(ag_a), 32'(tbl[i].ea));
      chk($sformatf("agen_b_s%0d_c%0d", tbl[i].stg, tbl[i].cnt), 32'(ag_b), 32'(tbl[i].eb));
    end

    @(negedge clk); nrst = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", 32'(cur_vec()), 32'd0);

    // abort and ready in IDLE do nothing
    abort = 1'b1; bif.bfly_ready = 1'b1;
    #1 chk("abort_idle_same", 32'(cur_vec()), 32'd0);
    @(negedge clk); abort = 1'b0;
    #1 chk("abort_idle_next", 32'(cur_vec()), 32'd0);
    @(negedge clk);

    full_run_checked("run1");

    // Random back-pressure against the reference twiddle counter
    kc0 = kc_tot; ke0 = ke_tot; dn0 = dn_tot;
    m_stage = 0; m_cnt = 0; done_seen = 0;
    bif.bfly_ready = 1'b0;
    launch();
    for (int c = 1; c < 6000 && !done_seen; c++) begin
      bif.bfly_ready = 1'($urandom_range(0, 1));
      #1;
      if (bif.bfly_valid) begin
        ab = ref_ab(m_stage, m_cnt);
        chk("rand_addr_stage", {8'd0, bif.stage_count_out, bif.addr_a, bif.addr_b},
            {8'd0, 4'(m_stage), ab});
        if (k_enable) begin
          chk("rand_tw_idx", 32'(tw_idx), 32'(m_cnt % (1 << m_stage)));
          if (m_cnt == 127) begin m_cnt = 0; m_stage++; end
          else m_cnt++;
        end
      end
      if (done) done_seen = 1;
      @(negedge clk);
    end
    chk("rand_done_seen", 32'(done_seen), 32'd1);
    chk("rand_kenable_cnt", ke_tot - ke0, 1024);
    chk("rand_kclear_cnt", kc_tot - kc0, 8);
    chk("rand_done_cnt", dn_tot - dn0, 1);

    // Abort in stage 3 at bfly_cnt=40 with a simultaneous accept
    bif.bfly_ready = 1'b1;
    dn0 = dn_tot;
    found = 0;
    launch();
    for (int c = 1; c < 2000 && !found; c++) begin
      #1;
      if (bif.bfly_valid && bif.stage_count_out == 4'd3 && bif.addr_a == 8'd80) found = 1;
      else @(negedge clk);
    end
    chk("abort_point_found", 32'(found), 32'd1);
    abort = 1'b1;
    #1;
    chk("abort_kclear_kenable", {30'd0, k_clear, k_enable}, 32'd3);
    @(negedge clk); abort = 1'b0;
    #1 chk("abort_next_idle", 32'(cur_vec()), 32'd0);
    repeat (4) @(negedge clk);
    chk("abort_no_done", dn_tot - dn0, 0);

    // start during RUN and in DONE ignored; start in following IDLE restarts
    @(negedge clk);
    launch();
    for (int c = 1; c <= 1034; c++) begin
      start = ((c >= 10 && c <= 12) || c == 1033);
      #1;
      if (c == 12)   chk("restart_run_ignored", 32'(cur_vec()), 32'(exp_vec(12)));
      if (c == 1033) chk("restart_done_cycle", 32'(cur_vec()), 32'(exp_vec(1033)));
      if (c == 1034) chk("restart_done_ignored", 32'(cur_vec()), 32'd0);
      if (c < 1034) @(negedge clk);
    end
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    #1 chk("restart_clear", 32'(cur_vec()), 32'(exp_vec(1)));
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    #1 chk("restart_abort_idle", 32'(cur_vec()), 32'd0);
    @(negedge clk);

    // Asynchronous reset mid stage 5
    found = 0;
    launch();
    for (int c = 1; c < 2000 && !found; c++) begin
      #1;
      if (bif.bfly_valid && bif.stage_count_out == 4'd5) found = 1;
      @(negedge clk);
    end
    chk("rst_point_found", 32'(found), 32'd1);
    repeat (7) @(negedge clk);
    #2 nrst = 1'b0;
    #1 chk("rst_mid_async", 32'(cur_vec()), 32'd0);
    @(negedge clk);
    chk("rst_mid_held", 32'(cur_vec()), 32'd0);
    nrst = 1'b1;
    @(negedge clk);
    full_run_checked("run2");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
